// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// FSM encoding, FUNC3 access codes and geometry constants.
package data_cache_pkg;

  localparam int unsigned TAG_W   = 25;
  localparam int unsigned INDEX_W = 3;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned LINES   = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    MEM_READ   = 2'd2,
    UPDATE     = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/data_cache_load_store_align.sv
// Combinational load extraction (sign/zero extension) and store byte-lane
// merge for a single 32-bit cache word.
module load_store_align
  import data_cache_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[7:0];
    case (byte_off)
      2'd0: sel_byte = word[7:0];
      2'd1: sel_byte = word[15:8];
      2'd2: sel_byte = word[23:16];
      2'd3: sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase
    // Halfword accesses ignore address bit 0 (aligned down).
    sel_half = byte_off[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (func3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'd0, sel_byte};
      F3_HU:   load_data = {16'd0, sel_half};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merged_word = word;
    case (func3)
      F3_B: begin
        case (byte_off)
          2'd0: merged_word[7:0]   = store_data[7:0];
          2'd1: merged_word[15:8]  = store_data[7:0];
          2'd2: merged_word[23:16] = store_data[7:0];
          2'd3: merged_word[31:24] = store_data[7:0];
          default: merged_word = word;
        endcase
      end
      F3_H: begin
        if (byte_off[1]) merged_word[31:16] = store_data[15:0];
        else             merged_word[15:0]  = store_data[15:0];
      end
      F3_W:    merged_word = store_data;
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back data cache, 8 lines x 16 B, with a block
// handshake to main memory. Optional DCACHE_STATS_EN adds hit/miss counters.
module data_cache
  import data_cache_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 READ,
  input  logic                 WRITE,
  input  logic [31:0]          ADDRESS,
  input  logic [31:0]          WRITEDATA,
  input  logic [2:0]           FUNC3,
  output logic [31:0]          READDATA,
  output logic                 BUSYWAIT,
  output logic                 MAIN_MEM_READ,
  output logic                 MAIN_MEM_WRITE,
  output logic [27:0]          MAIN_MEM_ADDRESS,
  output logic [BLOCK_W-1:0]   MAIN_MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]   MAIN_MEM_READDATA,
  input  logic                 MAIN_MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          HIT_COUNT,
  output logic [31:0]          MISS_COUNT
`endif
);

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] index;
  logic [1:0]         word_off;
  logic [1:0]         byte_off;

  assign req_tag  = ADDRESS[31:7];
  assign index    = ADDRESS[6:4];
  assign word_off = ADDRESS[3:2];
  assign byte_off = ADDRESS[1:0];

  logic [LINES-1:0]   valid;
  logic [LINES-1:0]   dirty;
  logic [TAG_W-1:0]   tags   [LINES];
  logic [BLOCK_W-1:0] blocks [LINES];

  state_t state, next_state;

  logic               access, hit, busy, store_hit;
  logic [BLOCK_W-1:0] cur_block, new_block;
  logic [31:0]        cur_word, load_data, merged_word;

  assign access    = READ | WRITE;
  assign hit       = access && valid[index] && (tags[index] == req_tag);
  assign cur_block = blocks[index];
  assign store_hit = (state == IDLE) && hit && WRITE;

  always_comb begin
    cur_word  = cur_block[31:0];
    new_block = cur_block;
    case (word_off)
      2'd0: begin cur_word = cur_block[31:0];   new_block[31:0]   = merged_word; end
      2'd1: begin cur_word = cur_block[63:32];  new_block[63:32]  = merged_word; end
      2'd2: begin cur_word = cur_block[95:64];  new_block[95:64]  = merged_word; end
      2'd3: begin cur_word = cur_block[127:96]; new_block[127:96] = merged_word; end
      default: begin cur_word = cur_block[31:0]; new_block = cur_block; end
    endcase
  end

  load_store_align u_align (
    .func3       (FUNC3),
    .byte_off    (byte_off),
    .word        (cur_word),
    .store_data  (WRITEDATA),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Simultaneous READ and WRITE is a store, so the load path is suppressed.
  assign READDATA = (READ && !WRITE) ? load_data : '0;

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (access && !hit) begin
          busy       = 1'b1;
          next_state = (valid[index] && dirty[index]) ? WRITE_BACK : MEM_READ;
        end
      end
      WRITE_BACK: begin
        busy = 1'b1;
        if (!MAIN_MEM_BUSYWAIT) next_state = MEM_READ;
      end
      MEM_READ: begin
        busy = 1'b1;
        if (!MAIN_MEM_BUSYWAIT) next_state = UPDATE;
      end
      UPDATE: begin
        busy       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign BUSYWAIT = busy && !RESET;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Memory-side outputs are registered from next_state so they track the
  // state register exactly and cannot glitch with the request inputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MAIN_MEM_READ      <= 1'b0;
      MAIN_MEM_WRITE     <= 1'b0;
      MAIN_MEM_ADDRESS   <= '0;
      MAIN_MEM_WRITEDATA <= '0;
    end else begin
      MAIN_MEM_READ  <= (next_state == MEM_READ);
      MAIN_MEM_WRITE <= (next_state == WRITE_BACK);
      if (state == IDLE && next_state == WRITE_BACK) begin
        MAIN_MEM_ADDRESS   <= {tags[index], index};
        MAIN_MEM_WRITEDATA <= cur_block;
      end else if (state != MEM_READ && next_state == MEM_READ) begin
        MAIN_MEM_ADDRESS <= {req_tag, index};
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (state == UPDATE) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (store_hit) begin
      dirty[index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      blocks[index] <= MAIN_MEM_READDATA;
      tags[index]   <= req_tag;
    end else if (store_hit) begin
      blocks[index] <= new_block;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else begin
      if (state == IDLE && hit)
        HIT_COUNT <= HIT_COUNT + 32'd1;
      if (state == IDLE && next_state != IDLE)
        MISS_COUNT <= MISS_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a latency-configurable main-memory model
// and scoreboards for load results and main-memory block transactions.
module tb_data_cache;
  import data_cache_pkg::*;

  localparam int LR = 3;
  localparam int LW = 2;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         READ, WRITE;
  logic [31:0]  ADDRESS, WRITEDATA;
  logic [2:0]   FUNC3;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic         MAIN_MEM_READ, MAIN_MEM_WRITE;
  logic [27:0]  MAIN_MEM_ADDRESS;
  logic [127:0] MAIN_MEM_WRITEDATA, MAIN_MEM_READDATA;
  logic         MAIN_MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
  logic [31:0]  HIT_COUNT, MISS_COUNT;
`endif

  data_cache dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .READ               (READ),
    .WRITE              (WRITE),
    .ADDRESS            (ADDRESS),
    .WRITEDATA          (WRITEDATA),
    .FUNC3              (FUNC3),
    .READDATA           (READDATA),
    .BUSYWAIT           (BUSYWAIT),
    .MAIN_MEM_READ      (MAIN_MEM_READ),
    .MAIN_MEM_WRITE     (MAIN_MEM_WRITE),
    .MAIN_MEM_ADDRESS   (MAIN_MEM_ADDRESS),
    .MAIN_MEM_WRITEDATA (MAIN_MEM_WRITEDATA),
    .MAIN_MEM_READDATA  (MAIN_MEM_READDATA),
    .MAIN_MEM_BUSYWAIT  (MAIN_MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT          (HIT_COUNT),
    .MISS_COUNT         (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Main memory: busy for LW/LR cycles from the first cycle of each request.
  logic [127:0] mem [256];
  logic [1:0]   req, prev_req;
  logic [31:0]  cnt, eff;
  int           lat;

  assign req               = {MAIN_MEM_WRITE, MAIN_MEM_READ};
  assign eff               = (req == prev_req) ? cnt : 32'd0;
  assign lat               = MAIN_MEM_WRITE ? LW : LR;
  assign MAIN_MEM_BUSYWAIT = (req != 2'b00) && (eff < 32'(lat));
  assign MAIN_MEM_READDATA = mem[MAIN_MEM_ADDRESS[7:0]];

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_req <= 2'b00;
      cnt      <= 32'd0;
    end else begin
      prev_req <= req;
      cnt      <= (req == prev_req) ? cnt + 32'd1 : 32'd1;
    end
  end

  typedef struct packed {
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } mm_t;
  mm_t mm_q[$];

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] stall;
  } exp_t;
  exp_t sb[$];

  // Transaction completes at the next edge when requested and not busy.
  always @(negedge CLK) begin
    if (req != 2'b00 && !MAIN_MEM_BUSYWAIT) begin
      if (mm_q.size() == 0) begin
        chk("mm_unexpected", {126'd0, req}, 128'd0);
      end else begin
        mm_t e;
        e = mm_q.pop_front();
        chk("mm_kind", {127'd0, MAIN_MEM_WRITE}, {127'd0, e.wr});
        chk("mm_addr", {100'd0, MAIN_MEM_ADDRESS}, {100'd0, e.addr});
        if (e.wr) chk("mm_wdata", MAIN_MEM_WRITEDATA, e.data);
      end
      if (MAIN_MEM_WRITE) mem[MAIN_MEM_ADDRESS[7:0]] = MAIN_MEM_WRITEDATA;
    end
  end

  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [31:0] exp_data,
                        input int exp_stall);
    exp_t e;
    int   stall;
    bit   done;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata; FUNC3 = f3;
    sb.push_back('{data: exp_data, stall: 32'(exp_stall)});
    stall = 0;
    done  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (BUSYWAIT) begin
        stall++;
        @(posedge CLK); #1;
      end else begin
        done = 1'b1;
      end
    end
    e = sb.pop_front();
    chk({tag, "_done"}, {127'd0, done}, 128'd1);
    chk({tag, "_data"}, {96'd0, READDATA}, {96'd0, e.data});
    chk({tag, "_stall"}, 128'(stall), {96'd0, e.stall});
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h04] = {32'h44444444, 32'h33333333, 32'h22222222, 32'hDEADBEEF};
    mem[8'h0C] = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0;
    ADDRESS = '0; WRITEDATA = '0; FUNC3 = F3_W;
    #22;
    chk("rst_busy", {127'd0, BUSYWAIT}, 128'd0);
    chk("rst_mmrd", {127'd0, MAIN_MEM_READ}, 128'd0);
    chk("rst_mmwr", {127'd0, MAIN_MEM_WRITE}, 128'd0);
    chk("rst_mmaddr", {100'd0, MAIN_MEM_ADDRESS}, 128'd0);
    chk("rst_mmwdata", MAIN_MEM_WRITEDATA, 128'd0);
`ifdef DCACHE_STATS_EN
    chk("rst_hits", {96'd0, HIT_COUNT}, 128'd0);
    chk("rst_misses", {96'd0, MISS_COUNT}, 128'd0);
`endif
    @(negedge CLK); RESET = 1'b0;
    @(posedge CLK); #1;

    mm_q.push_back('{wr: 1'b0, addr: 28'h0000004, data: '0});
    access("lw_clean_miss", 1, 0, 32'h40, 32'h0, F3_W, 32'hDEADBEEF, LR + 3);
    access("sb_41",   0, 1, 32'h41, 32'h12345680, F3_B,  32'h0, 0);
    access("lb_41",   1, 0, 32'h41, 32'h0, F3_B,  32'hFFFFFF80, 0);
    access("lbu_41",  1, 0, 32'h41, 32'h0, F3_BU, 32'h00000080, 0);
    access("lh_42",   1, 0, 32'h42, 32'h0, F3_H,  32'hFFFFDEAD, 0);
    access("lhu_43",  1, 0, 32'h43, 32'h0, F3_HU, 32'h0000DEAD, 0);
    access("sh_46",   0, 1, 32'h46, 32'hFFFF1234, F3_H, 32'h0, 0);
    access("lw_44",   1, 0, 32'h44, 32'h0, F3_W,  32'h12342222, 0);
    access("lh_47",   1, 0, 32'h47, 32'h0, F3_H,  32'h00001234, 0);
    access("rw_48",   1, 1, 32'h48, 32'hCAFEF00D, F3_W, 32'h0, 0);
    access("sw6_4c",  0, 1, 32'h4C, 32'h87654321, 3'b110, 32'h0, 0);
    access("lw_4c",   1, 0, 32'h4C, 32'h0, F3_W,  32'h87654321, 0);
    access("l7_4b",   1, 0, 32'h4B, 32'h0, 3'b111, 32'hCAFEF00D, 0);

    mm_q.push_back('{wr: 1'b1, addr: 28'h0000004,
                     data: {32'h87654321, 32'hCAFEF00D, 32'h12342222, 32'hDEAD80EF}});
    mm_q.push_back('{wr: 1'b0, addr: 28'h000000C, data: '0});
    access("lw_dirty_miss", 1, 0, 32'hC0, 32'h0, F3_W, 32'hC0C0C0C0, LW + LR + 4);

    // Abandon a block fetch with reset; the line must be refetched afterwards.
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 32'h40; FUNC3 = F3_W;
    @(negedge CLK);
    chk("mr_req_busy", {127'd0, BUSYWAIT}, 128'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("mr_active", {127'd0, MAIN_MEM_READ}, 128'd1);
    chk("mr_addr", {100'd0, MAIN_MEM_ADDRESS}, 128'h4);
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    chk("mr_rst_busy", {127'd0, BUSYWAIT}, 128'd0);
    chk("mr_rst_mmrd", {127'd0, MAIN_MEM_READ}, 128'd0);
    chk("mr_rst_addr", {100'd0, MAIN_MEM_ADDRESS}, 128'd0);
    READ = 1'b0;
    @(negedge CLK); RESET = 1'b0;
    @(posedge CLK); #1;

    mm_q.push_back('{wr: 1'b0, addr: 28'h0000004, data: '0});
    access("lw_after_rst", 1, 0, 32'h40, 32'h0, F3_W, 32'hDEAD80EF, LR + 3);
    access("hit_40", 1, 0, 32'h40, 32'h0, F3_W, 32'hDEAD80EF, 0);
    access("hit_41", 1, 0, 32'h41, 32'h0, F3_B, 32'hFFFFFF80, 0);
    access("hit_44", 1, 0, 32'h44, 32'h0, F3_W, 32'h12342222, 0);
`ifdef DCACHE_STATS_EN
    @(negedge CLK);
    chk("stat_misses", {96'd0, MISS_COUNT}, 128'd1);
    chk("stat_hits", {96'd0, HIT_COUNT}, 128'd4);
`endif

    repeat (2) @(posedge CLK);
    chk("mm_q_drained", 128'(mm_q.size()), 128'd0);
    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
